adc_sync_capture: RTL and testbench
===================================

Name: adc_sync_capture

Overview:
Parametrised multi-channel ADC acquisition sequencer. Triggers NUM_CH ADC front-ends (i2c-backed adc instances) together and captures each result independently as it completes. Converts each result to an unsigned voltage code and emits one sample_valid pulse when every enabled channel has been captured; this pulse gates the control algorithm. Adds a channel mask, per-stage timeout with per-channel error reporting, and trigger-overrun detection.

Parameters:
NUM_CH, 2, number of ADC channels (1..8)
DATA_W, 16, raw ADC word width (two's complement)
VOLT_W, 12, voltage code width; must be less than or equal to DATA_W-1
TIMEOUT_CYCLES, 27000, clk_i cycles allowed in each wait stage (1 ms at 27 MHz)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  conversion trigger, one-cycle pulse (e.g. PWM-synchronous trigger)
ch_mask_i  in  NUM_CH  channels taking part in the next acquisition; sampled on accepted start
adc_ready_i  in  NUM_CH  per-channel data-ready; low while busy
adc_data_i  in  NUM_CH*DATA_W  per-channel raw result; channel k occupies [k*DATA_W +: DATA_W]
adc_enable_o  out  NUM_CH  per-channel conversion enable
raw_o  out  NUM_CH*DATA_W  last captured raw word per channel
volt_o  out  NUM_CH*VOLT_W  last voltage code per channel
sample_valid_o  out  1  one-cycle pulse: new complete sample set
busy_o  out  1  high whenever the FSM is not in IDLE
timeout_o  out  1  sticky; set on abort, cleared by next sample_valid_o
err_ch_o  out  NUM_CH  channels that were not captured at the last abort; cleared with timeout_o
overrun_o  out  1  sticky; start_i arrived while busy; cleared only by reset

Behaviour:
- Reset: all outputs 0; raw/volt registers 0; FSM in IDLE; timer 0.
- FSM states: IDLE, WAIT_START, CAPTURE.
- IDLE: when start_i=1 and ch_mask_i!=0, latch mask_q=ch_mask_i, clear done_q, set adc_enable_o=mask_q, load timer, go to WAIT_START. If start_i=1 and ch_mask_i=0, ignore the trigger; there is no state change and no pulse.
- WAIT_START: when all channels in mask_q show adc_ready_i=0 in the same cycle, reload timer and go to CAPTURE. This prevents a stale ready from being captured.
- CAPTURE, per channel k in mask_q with done_q[k]=0 and adc_ready_i[k]=1: register raw[k]=data. volt[k]=0 if data[DATA_W-1]=1 (negative clamp); otherwise volt[k]=data[DATA_W-2 -: VOLT_W]. In the same edge, clear adc_enable_o[k] and set done_q[k]. Multiple channels may capture in one cycle.
- Completion: at the edge where (done_q | captures this cycle) covers mask_q, sample_valid_o is 1 for the next cycle only, and the FSM returns to IDLE. Latency is one clock from the last ready observed to the pulse. timeout_o and err_ch_o clear at the same edge.
- A start_i accepted in the cycle after the pulse (FSM already in IDLE) is legal.
- Timeout: the timer decrements each cycle in WAIT_START and CAPTURE. On reaching 0, all adc_enable_o go to 0, timeout_o is set, err_ch_o = mask_q & ~done_q (in WAIT_START this is all of mask_q), and the FSM returns to IDLE with no sample_valid_o. Channels already captured keep their new values; the others hold their previous values.
- Simultaneous ready and timer expiry on the same channel: the capture wins; if that completes the set, the completion is a success, not a timeout.
- start_i while busy_o=1: the trigger is ignored and overrun_o is set.
- Unmasked channels: adc_enable_o stays 0 and their outputs are untouched.
- Reset asserted mid-operation: immediate return to reset values, including deasserting all enables asynchronously.

Optional Feature:
ADC_FILTER_EN.
- Defined: volt[k] is updated with a first-order IIR, volt=(volt_prev+volt_new)>>1, computed at VOLT_W+1 bits and truncated. The first capture of channel k after reset loads the value directly, tracked by a per-channel primed flag.
- Undefined: volt[k] takes the converted value directly.
- raw_o is unfiltered in both cases.

Decomposition:
- Package adc_sync_pkg holds the state enum (IDLE/WAIT_START/CAPTURE), the timer width function clog2(TIMEOUT_CYCLES+1), and the voltage-clamp/slice function.
- Sub-module adc_ch_capture handles one channel's capture register, clamp, optional filter and primed flag. It is instantiated NUM_CH times via generate; the top level holds the FSM, timer, mask and flags.

Test Plan:
- NUM_CH=2, mask=2'b11; ready drops 3 cycles after enable; ch0 data 16'h4CCE at t+10, ch1 16'h733A at t+25 -> volt0=12'h999, volt1=12'hE67; enable0 drops at t+10; single sample_valid pulse at t+26.
- ch1 data 16'h8123 (negative) -> volt1=0, raw1=16'h8123, sample_valid pulses normally.
- mask=2'b01, ch1 ready held high -> adc_enable_o[1]=0 throughout; pulse after ch0 only; raw1/volt1 unchanged.
- TIMEOUT_CYCLES=50; ch1 never returns ready -> at cycle 50 all enables go to 0, timeout_o=1, err_ch_o=2'b10, no pulse; next good acquisition clears timeout_o and err_ch_o.
- Both readies high in the same cycle, coinciding with timer expiry -> both captured, sample_valid=1, timeout_o=0.
- start_i pulsed during CAPTURE -> overrun_o=1 and the sequence is unaffected. Reset asserted mid-CAPTURE -> all outputs 0 in the same cycle. With ADC_FILTER_EN, ch0 values 0x0800 then 0x0400 (volt 256 then 128) -> volt0=256, then 192.

Source files
------------

// File: rtl/adc_sync_pkg.sv
// rtl/adc_sync_pkg.sv - shared types and helpers for the synchronous multi-channel ADC sequencer
package adc_sync_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    while ((64'd1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Two's-complement raw word to unsigned voltage code: negatives clamp to
  // zero, otherwise take the volt_w bits just below the sign bit.
  function automatic logic [31:0] volt_convert(input logic [63:0] data,
                                               input int          data_w,
                                               input int          volt_w);
    logic [31:0] field_mask;
    if (data[data_w-1]) begin
      return 32'd0;
    end
    field_mask = (32'd1 << volt_w) - 32'd1;
    return 32'(data >> (data_w - 1 - volt_w)) & field_mask;
  endfunction

endpackage

// File: rtl/adc_ch_capture.sv
// rtl/adc_ch_capture.sv - one channel's raw/voltage capture registers
// Optional IIR smoothing of the voltage code when ADC_FILTER_EN is defined.
module adc_ch_capture
  import adc_sync_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int VOLT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] raw,
  output logic [VOLT_W-1:0] volt
);

  logic [VOLT_W-1:0] volt_new;

  assign volt_new = VOLT_W'(volt_convert(64'(data), DATA_W, VOLT_W));

`ifdef ADC_FILTER_EN
  logic            primed;
  logic [VOLT_W:0] volt_sum;

  assign volt_sum = {1'b0, volt} + {1'b0, volt_new};

  // The first sample after reset seeds the filter instead of averaging with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw    <= '0;
      volt   <= '0;
      primed <= 1'b0;
    end else if (capture) begin
      raw    <= data;
      volt   <= primed ? volt_sum[VOLT_W:1] : volt_new;
      primed <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw  <= '0;
      volt <= '0;
    end else if (capture) begin
      raw  <= data;
      volt <= volt_new;
    end
  end
`endif

endmodule

// File: rtl/adc_sync_capture.sv
// rtl/adc_sync_capture.sv - triggers NUM_CH ADCs together and reports a complete sample set
// Optional voltage IIR filter in each channel: define ADC_FILTER_EN.
module adc_sync_capture
  import adc_sync_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 16,
  parameter int VOLT_W         = 12,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic [NUM_CH-1:0]        adc_ready_i,
  input  logic [NUM_CH*DATA_W-1:0] adc_data_i,
  output logic [NUM_CH-1:0]        adc_enable_o,
  output logic [NUM_CH*DATA_W-1:0] raw_o,
  output logic [NUM_CH*VOLT_W-1:0] volt_o,
  output logic                     sample_valid_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [NUM_CH-1:0]        err_ch_o,
  output logic                     overrun_o
);

  localparam int TW = clog2(64'(TIMEOUT_CYCLES) + 64'd1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  logic              ovr_q, ovr_d;

  logic [NUM_CH-1:0] capt;
  logic [NUM_CH-1:0] got;
  logic              all_done;
  logic              expire;

  // A stage expires on its TIMEOUT_CYCLES-th clock; captures on that clock still count.
  assign capt     = (state_q == CAPTURE) ? (mask_q & ~done_q & adc_ready_i) : '0;
  assign got      = done_q | capt;
  assign all_done = ((got & mask_q) == mask_q);
  assign expire   = (timer_q <= TW'(1));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = done_q;
    en_d    = en_q;
    err_d   = err_q;
    timer_d = timer_q;
    valid_d = 1'b0;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q | (start_i && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start_i && (ch_mask_i != '0)) begin
          mask_d  = ch_mask_i;
          done_d  = '0;
          en_d    = ch_mask_i;
          timer_d = TIMER_LOAD;
          state_d = WAIT_START;
        end
      end

      // Wait for every enabled ADC to go busy so a stale ready is never captured.
      WAIT_START: begin
        if ((adc_ready_i & mask_q) == '0) begin
          timer_d = TIMER_LOAD;
          state_d = CAPTURE;
        end else if (expire) begin
          en_d    = '0;
          tmo_d   = 1'b1;
          err_d   = mask_q;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      CAPTURE: begin
        done_d = got;
        en_d   = en_q & ~capt;
        if (all_done) begin
          valid_d = 1'b1;
          tmo_d   = 1'b0;
          err_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else if (expire) begin
          en_d    = '0;
          tmo_d   = 1'b1;
          err_d   = mask_q & ~got;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        en_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= '0;
      en_q    <= '0;
      err_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      en_q    <= en_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_ch_capture #(
      .DATA_W (DATA_W),
      .VOLT_W (VOLT_W)
    ) u_ch (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .capture (capt[k]),
      .data    (adc_data_i[k*DATA_W +: DATA_W]),
      .raw     (raw_o[k*DATA_W +: DATA_W]),
      .volt    (volt_o[k*VOLT_W +: VOLT_W])
    );
  end

  assign adc_enable_o   = en_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign timeout_o      = tmo_q;
  assign err_ch_o       = err_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_sync_capture.sv
// tb/tb_adc_sync_capture.sv - directed and randomized acquisitions against a cycle-count reference model
module tb_adc_sync_capture;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  ch_mask;
  logic [1:0]  adc_ready;
  logic [31:0] adc_data;
  logic [1:0]  adc_enable;
  logic [31:0] raw;
  logic [23:0] volt;
  logic        sample_valid;
  logic        busy;
  logic        timeout;
  logic [1:0]  err_ch;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_raw[2];
  int          exp_volt[2];
  bit          primed[2];
  bit          exp_tmo;
  bit          exp_ovr;
  logic [1:0]  exp_err;

  adc_sync_capture #(
    .NUM_CH         (2),
    .DATA_W         (16),
    .VOLT_W         (12),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .ch_mask_i      (ch_mask),
    .adc_ready_i    (adc_ready),
    .adc_data_i     (adc_data),
    .adc_enable_o   (adc_enable),
    .raw_o          (raw),
    .volt_o         (volt),
    .sample_valid_o (sample_valid),
    .busy_o         (busy),
    .timeout_o      (timeout),
    .err_ch_o       (err_ch),
    .overrun_o      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rdy_at(input int drop, input int ret, input int n);
    return (n < drop) || (n >= ret);
  endfunction

  function automatic int to_volt(input logic [15:0] d);
    if ($signed(d) < 0) return 0;
    return int'(d) / 8;
  endfunction

  function automatic int filt(input int k, input int v);
`ifdef ADC_FILTER_EN
    if (primed[k]) return (exp_volt[k] + v) / 2;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_raw[k]  = '0;
      exp_volt[k] = 0;
      primed[k]   = 1'b0;
    end
    exp_tmo = 1'b0;
    exp_ovr = 1'b0;
    exp_err = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_raw"}, 64'(raw), 64'({exp_raw[1], exp_raw[0]}));
    check({tag, "_volt"}, 64'(volt), 64'({12'(exp_volt[1]), 12'(exp_volt[0])}));
    check({tag, "_timeout"}, 64'(timeout), 64'(exp_tmo));
    check({tag, "_err_ch"}, 64'(err_ch), 64'(exp_err));
    check({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
  endtask

  // Called just after a negedge; starts the acquisition at that cycle. Each ADC
  // shows ready below cycle drop, busy until cycle ret, then ready with its value.
  task automatic acquire(input string tag, input logic [1:0] mask,
                         input int dr0, input int dr1, input int rt0, input int rt1,
                         input logic [15:0] v0, input logic [15:0] v1, input int ovr_at);
    int          drop[2];
    int          ret[2];
    logic [15:0] val[2];
    int          cap[2];
    int          w;
    int          fin;
    bit          ok;
    bit          low;
    logic [1:0]  en_exp;
    drop = '{dr0, dr1};
    ret  = '{rt0, rt1};
    val  = '{v0, v1};
    cap  = '{0, 0};

    w = 0;
    for (int n = 1; n <= T && w == 0; n++) begin
      low = 1'b1;
      for (int k = 0; k < 2; k++) if (mask[k] && rdy_at(drop[k], ret[k], n)) low = 1'b0;
      if (low) w = n;
    end
    ok  = 1'b0;
    fin = T;
    if (w != 0) begin
      ok  = 1'b1;
      fin = 0;
      for (int k = 0; k < 2; k++) begin
        if (mask[k]) begin
          for (int n = w + 1; n <= w + T && cap[k] == 0; n++)
            if (rdy_at(drop[k], ret[k], n)) cap[k] = n;
          if (cap[k] == 0) ok = 1'b0;
          else if (cap[k] > fin) fin = cap[k];
        end
      end
      if (!ok) fin = w + T;
    end

    for (int m = 0; m <= fin + 1; m++) begin
      if (m > 0) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++)
          en_exp[k] = mask[k] && (m <= ((cap[k] != 0) ? cap[k] : fin));
        check({tag, "_busy"}, 64'(busy), 64'(m <= fin));
        check({tag, "_sample_valid"}, 64'(sample_valid), 64'(ok && (m == fin + 1)));
        check({tag, "_adc_enable"}, 64'(adc_enable), 64'(en_exp));
      end
      start   = (m == 0) || (m == ovr_at);
      ch_mask = mask;
      for (int k = 0; k < 2; k++) begin
        adc_ready[k]         = rdy_at(drop[k], ret[k], m);
        adc_data[k*16 +: 16] = (m >= ret[k]) ? val[k] : 16'($urandom);
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (cap[k] != 0) begin
        exp_raw[k]  = val[k];
        exp_volt[k] = filt(k, to_volt(val[k]));
        primed[k]   = 1'b1;
      end
    end
    if (ok) begin
      exp_tmo = 1'b0;
      exp_err = '0;
    end else begin
      exp_tmo = 1'b1;
      for (int k = 0; k < 2; k++) exp_err[k] = mask[k] && (cap[k] == 0);
    end
    if (ovr_at >= 1 && ovr_at <= fin) exp_ovr = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    logic [1:0] rm;
    rst_n     = 1'b0;
    start     = 1'b0;
    ch_mask   = '0;
    adc_ready = 2'b11;
    adc_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_enable", 64'(adc_enable), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valid", 64'(sample_valid), 64'(0));
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Trigger with an empty mask is ignored.
    start   = 1'b1;
    ch_mask = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("zero_mask_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("zero_mask_enable", 64'(adc_enable), 64'(0));

    acquire("basic", 2'b11, 3, 3, 10, 25, 16'h4CCE, 16'h733A, 0);
    check("basic_volt_const", 64'(volt), 64'({12'hE67, 12'h999}));

    acquire("negative", 2'b11, 3, 3, 6, 9, 16'h1234, 16'h8123, 0);
`ifndef ADC_FILTER_EN
    check("negative_volt1", 64'(volt[23:12]), 64'(0));
`endif
    check("negative_raw1", 64'(raw[31:16]), 64'(16'h8123));

    acquire("mask01", 2'b01, 3, 1000, 7, 2000, 16'h2468, 16'h0BAD, 0);
    acquire("cap_timeout", 2'b11, 3, 3, 10, 1000, 16'h3000, 16'h7000, 0);
    check("cap_timeout_err", 64'(err_ch), 64'(2'b10));
    acquire("recover", 2'b11, 2, 2, 5, 6, 16'h1111, 16'h2222, 0);
    check("recover_timeout", 64'(timeout), 64'(0));
    acquire("wait_timeout", 2'b01, 1000, 3, 2000, 9, 16'h5555, 16'h6666, 0);
    acquire("expiry_tie", 2'b11, 3, 3, 3 + T, 3 + T, 16'h0F0F, 16'h7F7F, 0);
    check("expiry_tie_timeout", 64'(timeout), 64'(0));
    acquire("overrun", 2'b11, 3, 3, 10, 20, 16'h4000, 16'h2000, 12);
    check("overrun_flag", 64'(overrun), 64'(1));

    for (int i = 0; i < 12; i++) begin
      int d0, d1;
      rm = 2'($urandom_range(1, 3));
      d0 = int'($urandom_range(1, 6));
      d1 = int'($urandom_range(1, 6));
      acquire("random", rm, d0, d1, d0 + int'($urandom_range(1, 60)), d1 + int'($urandom_range(1, 60)),
              16'($urandom), 16'($urandom), 0);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    // Asynchronous reset in the middle of a capture.
    start     = 1'b1;
    ch_mask   = 2'b11;
    adc_ready = 2'b11;
    @(negedge clk);
    start     = 1'b0;
    adc_ready = 2'b00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_enable", 64'(adc_enable), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    check_outputs("midreset");
    @(negedge clk);
    rst_n     = 1'b1;
    adc_ready = 2'b11;
    @(negedge clk);

    acquire("filter_a", 2'b01, 2, 2, 6, 6, 16'h0800, 16'h0000, 0);
    check("filter_a_volt0", 64'(volt[11:0]), 64'(256));
    acquire("filter_b", 2'b01, 2, 2, 6, 6, 16'h0400, 16'h0000, 0);
`ifdef ADC_FILTER_EN
    check("filter_b_volt0", 64'(volt[11:0]), 64'(192));
`else
    check("filter_b_volt0", 64'(volt[11:0]), 64'(128));
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
